mfp_multi_digit_seven_segment_scanner: RTL and testbench
========================================================

// Module: mfp_multi_digit_seven_segment_scanner
// PURPOSE
//  Time-multiplexed N-digit hex 7-segment driver for boards with shared segment lines and per-digit enables.
//  Generalises the per-digit static decoder; adds scan sequencing, anti-ghost dead time, tear-free frame snapshot,
//  per-digit blanking and leading-zero suppression. Sits between mfp_system IO_7_SegmentHEX and board pins.
// PARAMETERS
//  N_DIGITS        8     digits scanned; 1..16
//  DIGIT_CYCLES    50000 clk cycles per digit slot; >= 2
//  DEAD_CYCLES     500   blank cycles at start of each slot; 0 <= DEAD_CYCLES < DIGIT_CYCLES
//  ANODE_ACT_LOW   1     1: anodes active-low at pins
//  SEG_ACT_LOW     1     1: segments/dp active-low at pins
// PORTS
//  clk        in  1           system clock
//  reset      in  1           asynchronous, active-high reset
//  en         in  1           1: scan runs; 0: counters hold, all outputs inactive
//  hex        in  4*N_DIGITS  digit i = hex[4i+3:4i]; digit 0 rightmost
//  dp         in  N_DIGITS    decimal point per digit, 1 = lit
//  digit_en   in  N_DIGITS    1 = digit may light; 0 = forced blank (dp too)
//  lzb        in  1           1 = suppress leading zeros
//  anodes     out N_DIGITS    digit enables, polarity per ANODE_ACT_LOW
//  segments   out 7           {g,f,e,d,c,b,a}, polarity per SEG_ACT_LOW
//  seg_dp     out 1           decimal point, polarity per SEG_ACT_LOW
//  frame_strobe out 1         one-cycle pulse when a new snapshot is taken
// BEHAVIOUR
//  Reset: slot counter 0, digit index 0, state BLANK, snapshot regs 0; anodes/segments/seg_dp inactive level,
//   frame_strobe 0. Reset mid-scan returns here immediately (async); first snapshot taken on first enabled cycle.
//  Counters: cyc counts 0..DIGIT_CYCLES-1 per slot; idx counts 0..N_DIGITS-1, increments on cyc wrap, idx wraps to 0.
//  FSM (registered outputs, all driven from state/counters of the same cycle -> 1 clk output latency):
//   BLANK: all anodes inactive; -> DRIVE when cyc == DEAD_CYCLES-1 (DEAD_CYCLES=0: BLANK never entered after reset,
//          first enabled cycle goes straight to DRIVE).
//   DRIVE: anode[idx] active only; segments = glyph(snap_hex[idx]); seg_dp = snap_dp[idx];
//          on cyc wrap -> BLANK (or stay DRIVE if DEAD_CYCLES=0) with idx advanced.
//  Snapshot: hex, dp, digit_en, lzb captured together on first enabled cycle after reset and on every cycle where
//   cyc wraps and idx == N_DIGITS-1; frame_strobe asserted that same cycle. Inputs otherwise ignored (no tearing).
//  Glyphs (active-high gfedcba): 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07 8=7F 9=6F A=77 b=7C C=39 d=5E E=79 F=71.
//  Blank digit: segments and dp inactive, anode still scanned active (constant duty). A digit is blank if
//   snap_digit_en[i]=0, or snap_lzb=1 and i>0 and snap_hex digits i..N_DIGITS-1 all zero and snap_dp digits i..N-1 all 0.
//   Digit 0 never blanked by lzb.
//  en=0: cyc/idx/state hold; anodes, segments, seg_dp inactive next cycle; frame_strobe 0; resume from held point.
//  Polarity: internal active-high, inverted at output register when *_ACT_LOW=1. Exactly one anode active in DRIVE,
//   none in BLANK; no cycle ever has two anodes active.
// TESTING (N_DIGITS=4, DIGIT_CYCLES=8, DEAD_CYCLES=2, both ACT_LOW=1)
//  Reset then en=1, hex=16'h12AF, digit_en=F, lzb=0 -> frame_strobe on first cycle; per slot 2 cycles anodes=4'hF,
//   6 cycles anodes=~(1<<idx); idx0 segments=~7'h71, idx1 ~7'h77, idx2 ~7'h5B, idx3 ~7'h06; frame period 32 clks.
//  Change hex to 16'h0000 while idx=1 -> displayed digits unchanged until next frame_strobe, then all show ~7'h3F.
//  lzb=1, hex=16'h0070, dp=0 -> digit3 and digit2 segments 7'h7F (blank), digit1 ~7'h07, digit0 ~7'h3F; hex=0 ->
//   only digit0 lit; dp=4'b1000 with hex=0 -> digit3 shows dp, digits 2..1 still not blanked by lzb.
//  digit_en=4'b1010 -> digits 0,2 blank (segments 7'h7F, seg_dp 1) while anodes still scan all four.
//  en=0 for 5 cycles mid-DRIVE -> outputs inactive next cycle, counters frozen; en=1 -> resumes at same cyc/idx.
//  Assert reset mid-DRIVE (async, off clock edge) -> anodes=4'hF, segments=7'h7F immediately; check never >1 anode.

Source files
------------

// File: rtl/mfp_multi_digit_seven_segment_scanner.sv
// mfp_multi_digit_seven_segment_scanner
//   Time-multiplexed hex driver for N 7-segment digits that share segment lines
//   and have one enable (anode) each. Each digit owns a slot of DIGIT_CYCLES clocks.
//   The first DEAD_CYCLES clocks of a slot keep every anode off, so the previous
//   digit's pattern cannot ghost onto the next one. All inputs are sampled together
//   once per frame, so a frame never mixes old and new values.
//
// Ports
//   clk          system clock
//   reset        asynchronous, active-high reset
//   en           1: scanning runs; 0: scan position frozen and all outputs inactive
//   hex          4 bits per digit, digit 0 (rightmost) in hex[3:0]
//   dp           decimal point per digit, 1 = lit
//   digit_en     per-digit enable; 0 forces that digit (and its dp) blank
//   lzb          1 = suppress leading zeros
//   anodes       digit enables at pin polarity
//   segments     {g,f,e,d,c,b,a} at pin polarity
//   seg_dp       decimal point at pin polarity
//   frame_strobe one-cycle pulse marking a fresh input snapshot
module mfp_multi_digit_seven_segment_scanner #(
    parameter int N_DIGITS      = 8,
    parameter int DIGIT_CYCLES  = 50000,
    parameter int DEAD_CYCLES   = 500,
    parameter int ANODE_ACT_LOW = 1,
    parameter int SEG_ACT_LOW   = 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    en,
    input  logic [4*N_DIGITS-1:0]   hex,
    input  logic [N_DIGITS-1:0]     dp,
    input  logic [N_DIGITS-1:0]     digit_en,
    input  logic                    lzb,
    output logic [N_DIGITS-1:0]     anodes,
    output logic [6:0]              segments,
    output logic                    seg_dp,
    output logic                    frame_strobe
);

    localparam int IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
    localparam int CYC_W = $clog2(DIGIT_CYCLES);

    localparam logic [CYC_W-1:0] CYC_LAST  = CYC_W'(DIGIT_CYCLES - 1);
    localparam logic [CYC_W-1:0] DEAD_LAST = CYC_W'((DEAD_CYCLES > 0) ? DEAD_CYCLES - 1 : 0);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(N_DIGITS - 1);

    // Inactive pin levels; XOR with these converts internal active-high to pin polarity.
    localparam logic [N_DIGITS-1:0] AN_OFF  = {N_DIGITS{ANODE_ACT_LOW != 0}};
    localparam logic [6:0]          SEG_OFF = {7{SEG_ACT_LOW != 0}};
    localparam logic                DP_OFF  = (SEG_ACT_LOW != 0);

    typedef enum logic {
        S_BLANK,
        S_DRIVE
    } state_t;

    // With no dead time the scanner lives in DRIVE permanently.
    localparam state_t RESET_STATE = (DEAD_CYCLES == 0) ? S_DRIVE : S_BLANK;

    function automatic logic [6:0] glyph(input logic [3:0] v);
        case (v)
            4'h0: glyph = 7'h3F;
            4'h1: glyph = 7'h06;
            4'h2: glyph = 7'h5B;
            4'h3: glyph = 7'h4F;
            4'h4: glyph = 7'h66;
            4'h5: glyph = 7'h6D;
            4'h6: glyph = 7'h7D;
            4'h7: glyph = 7'h07;
            4'h8: glyph = 7'h7F;
            4'h9: glyph = 7'h6F;
            4'hA: glyph = 7'h77;
            4'hB: glyph = 7'h7C;
            4'hC: glyph = 7'h39;
            4'hD: glyph = 7'h5E;
            4'hE: glyph = 7'h79;
            default: glyph = 7'h71;
        endcase
    endfunction

    state_t                state_q, state_d;
    logic [CYC_W-1:0]      cyc_q, cyc_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic                  started_q, started_d;
    logic [4*N_DIGITS-1:0] snap_hex_q, snap_hex_d;
    logic [N_DIGITS-1:0]   snap_dp_q, snap_dp_d;
    logic [N_DIGITS-1:0]   snap_den_q, snap_den_d;
    logic                  snap_lzb_q, snap_lzb_d;
    logic [N_DIGITS-1:0]   anodes_q, anodes_d;
    logic [6:0]            segments_q, segments_d;
    logic                  seg_dp_q, seg_dp_d;
    logic                  strobe_q, strobe_d;

    logic [4*N_DIGITS-1:0] hex_eff;
    logic [N_DIGITS-1:0]   dp_eff;
    logic [N_DIGITS-1:0]   den_eff;
    logic                  lzb_eff;
    logic [N_DIGITS-1:0]   dig_blank;
    logic [N_DIGITS-1:0]   an_hi;
    logic                  zero_run;
    logic                  cyc_wrap;
    logic                  take_snap;

    // Before the first snapshot exists the live inputs stand in for it, so a
    // zero-dead-time configuration never shows the reset contents of the snapshot.
    always_comb begin
        hex_eff = started_q ? snap_hex_q : hex;
        dp_eff  = started_q ? snap_dp_q  : dp;
        den_eff = started_q ? snap_den_q : digit_en;
        lzb_eff = started_q ? snap_lzb_q : lzb;
    end

    // Leading-zero run scanned from the most significant digit down; a lit dp ends it.
    always_comb begin
        zero_run  = 1'b1;
        dig_blank = '0;
        for (int i = N_DIGITS - 1; i >= 0; i--) begin
            zero_run     = zero_run & (hex_eff[4*i +: 4] == 4'h0) & ~dp_eff[i];
            dig_blank[i] = ~den_eff[i] | (lzb_eff & zero_run & (i > 0));
        end
    end

    always_comb begin
        an_hi = '0;
        for (int i = 0; i < N_DIGITS; i++) begin
            an_hi[i] = (idx_q == IDX_W'(i));
        end
    end

    assign cyc_wrap  = (cyc_q == CYC_LAST);
    assign take_snap = en & (~started_q | (cyc_wrap & (idx_q == IDX_LAST)));

    always_comb begin
        state_d    = state_q;
        cyc_d      = cyc_q;
        idx_d      = idx_q;
        started_d  = started_q;
        snap_hex_d = snap_hex_q;
        snap_dp_d  = snap_dp_q;
        snap_den_d = snap_den_q;
        snap_lzb_d = snap_lzb_q;
        anodes_d   = AN_OFF;
        segments_d = SEG_OFF;
        seg_dp_d   = DP_OFF;
        strobe_d   = 1'b0;

        if (en) begin
            started_d = 1'b1;
            if (take_snap) begin
                snap_hex_d = hex;
                snap_dp_d  = dp;
                snap_den_d = digit_en;
                snap_lzb_d = lzb;
                strobe_d   = 1'b1;
            end

            if (cyc_wrap) begin
                cyc_d = '0;
                idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
            end else begin
                cyc_d = cyc_q + 1'b1;
            end

            case (state_q)
                S_BLANK: begin
                    if (cyc_q == DEAD_LAST) state_d = S_DRIVE;
                end
                default: begin
                    anodes_d = an_hi ^ AN_OFF;
                    // A blank digit keeps its anode slot so brightness stays uniform.
                    if (!dig_blank[idx_q]) begin
                        segments_d = glyph(hex_eff[{idx_q, 2'b00} +: 4]) ^ SEG_OFF;
                        seg_dp_d   = dp_eff[idx_q] ^ DP_OFF;
                    end
                    if (cyc_wrap) state_d = RESET_STATE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= RESET_STATE;
            cyc_q      <= '0;
            idx_q      <= '0;
            started_q  <= 1'b0;
            snap_hex_q <= '0;
            snap_dp_q  <= '0;
            snap_den_q <= '0;
            snap_lzb_q <= 1'b0;
            anodes_q   <= AN_OFF;
            segments_q <= SEG_OFF;
            seg_dp_q   <= DP_OFF;
            strobe_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            cyc_q      <= cyc_d;
            idx_q      <= idx_d;
            started_q  <= started_d;
            snap_hex_q <= snap_hex_d;
            snap_dp_q  <= snap_dp_d;
            snap_den_q <= snap_den_d;
            snap_lzb_q <= snap_lzb_d;
            anodes_q   <= anodes_d;
            segments_q <= segments_d;
            seg_dp_q   <= seg_dp_d;
            strobe_q   <= strobe_d;
        end
    end

    assign anodes       = anodes_q;
    assign segments     = segments_q;
    assign seg_dp       = seg_dp_q;
    assign frame_strobe = strobe_q;

endmodule

// File: tb/tb_mfp_multi_digit_seven_segment_scanner.sv
module tb_mfp_multi_digit_seven_segment_scanner;

    logic        clk = 1'b0;
    logic        reset;
    logic        en;
    logic [15:0] hex;
    logic [3:0]  dp;
    logic [3:0]  digit_en;
    logic        lzb;
    logic [3:0]  anodes;
    logic [6:0]  segments;
    logic        seg_dp;
    logic        frame_strobe;

    int checks = 0;
    int errors = 0;

    mfp_multi_digit_seven_segment_scanner #(
        .N_DIGITS(4), .DIGIT_CYCLES(8), .DEAD_CYCLES(2),
        .ANODE_ACT_LOW(1), .SEG_ACT_LOW(1)
    ) dut (
        .clk(clk), .reset(reset), .en(en), .hex(hex), .dp(dp),
        .digit_en(digit_en), .lzb(lzb), .anodes(anodes), .segments(segments),
        .seg_dp(seg_dp), .frame_strobe(frame_strobe)
    );

    always #5 clk = ~clk;

    // Active-high glyph table, written out by hand.
    logic [6:0] GLYPH [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                               7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    // Expected {anodes, segments, seg_dp, frame_strobe} after each clock edge.
    logic [12:0] exp_q [$];

    // Reference model: one position counter over the 32-clock frame.
    int          m_t;
    bit          m_started;
    logic [15:0] m_hex;
    logic [3:0]  m_dp;
    logic [3:0]  m_den;
    logic        m_lzb;

    function automatic bit m_blank(input int slot);
        int msd;
        msd = 0;
        for (int i = 0; i < 4; i++)
            if (m_hex[4*i +: 4] != 4'h0 || m_dp[i]) msd = i;
        return !m_den[slot] || (m_lzb && slot > msd);
    endfunction

    task automatic model_reset();
        m_t = 0; m_started = 0; m_hex = '0; m_dp = '0; m_den = '0; m_lzb = 0;
    endtask

    task automatic push_expect();
        logic [3:0] an;
        logic [6:0] sg;
        logic       p, st;
        logic [3:0] one;
        int         slot;
        an = 4'hF; sg = 7'h7F; p = 1'b1; st = 1'b0; one = 4'b0001;
        if (en) begin
            slot = m_t / 8;
            if ((m_t % 8) >= 2) begin
                an = ~(one << slot);
                if (!m_blank(slot)) begin
                    sg = ~GLYPH[m_hex[4*slot +: 4]];
                    p  = ~m_dp[slot];
                end
            end
            if (!m_started || m_t == 31) begin
                m_hex = hex; m_dp = dp; m_den = digit_en; m_lzb = lzb;
                m_started = 1; st = 1'b1;
            end
            m_t = (m_t + 1) % 32;
        end
        exp_q.push_back({an, sg, p, st});
    endtask

    task automatic step(input int n);
        for (int k = 0; k < n; k++) begin
            push_expect();
            @(posedge clk);
            #2;
        end
    endtask

    task automatic check_now(input string name, input logic [12:0] act, input logic [12:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s got=%h expected=%h", name, act, req);
        end
    endtask

    // Monitor: every falling edge, pop the expected response for the preceding rising edge.
    initial begin
        logic [12:0] e;
        forever begin
            @(negedge clk);
            if (!reset) begin
                checks++;
                if ($countones(~anodes) > 1) begin
                    errors++;
                    $display("FAIL onehot anodes=%b expected at most one low", anodes);
                end
            end
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checks++;
                if ({anodes, segments, seg_dp, frame_strobe} !== e) begin
                    errors++;
                    $display("FAIL scan t=%0t got an=%b seg=%h dp=%b fs=%b expected an=%b seg=%h dp=%b fs=%b",
                             $time, anodes, segments, seg_dp, frame_strobe,
                             e[12:9], e[8:2], e[1], e[0]);
                end
            end
        end
    end

    initial begin
        reset = 1'b1; en = 1'b0; hex = 16'h0; dp = 4'h0; digit_en = 4'hF; lzb = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check_now("reset_state", {anodes, segments, seg_dp, frame_strobe}, {4'hF, 7'h7F, 1'b1, 1'b0});

        // Normal scan, then a mid-frame change that must wait for the next frame.
        en = 1'b1; hex = 16'h12AF;
        step(42);
        hex = 16'h0000;
        step(54);

        // Leading-zero suppression variants.
        lzb = 1'b1; hex = 16'h0070; dp = 4'h0;
        step(64);
        hex = 16'h0000;
        step(64);
        dp = 4'b1000;
        step(64);

        // Per-digit blanking with anodes still scanning.
        lzb = 1'b0; dp = 4'h0; hex = 16'h1234; digit_en = 4'b1010;
        step(64);

        // Pause mid-DRIVE and resume.
        digit_en = 4'hF;
        step(12);
        en = 1'b0;
        step(5);
        en = 1'b1;
        step(20);

        // Asynchronous reset mid-DRIVE, off the clock edge.
        step(5);
        @(negedge clk);
        #1;
        reset = 1'b1;
        #1;
        check_now("async_reset", {anodes, segments, seg_dp, frame_strobe}, {4'hF, 7'h7F, 1'b1, 1'b0});
        model_reset();
        @(posedge clk);
        @(negedge clk);
        #1;
        reset = 1'b0;
        hex = 16'h12AF;
        step(40);

        for (int k = 0; k < 4 && exp_q.size() > 0; k++) @(negedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain pending=%0d expected=0", exp_q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
